// File: rtl/alu_result_buffer.sv
// alu_result_buffer: registered output FIFO for the 8-bit ALU datapath.
// Each accepted result is stored with zero/neg/parity flags that are computed when it is written.
// The head entry is shown directly from storage.
// in_ready and out_valid are decoded from the registered count only.
module alu_result_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic          out_zero,
  output logic          out_neg,
  output logic          out_parity,
  output logic [CW-1:0] count,
  output logic          overrun
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Entry layout: {parity, neg, zero, data[7:0]}
  localparam int unsigned EW = 11;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overrun_q, overrun_d;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head_entry;

  // Handshake decode from registered occupancy only
  always_comb begin
    full      = (count_q == CW'(DEPTH));
    empty     = (count_q == '0);
    in_ready  = ~full;
    out_valid = ~empty;
    push      = in_valid & ~full;
    pop       = ~empty & out_ready;
  end

  // Status flags are computed from the incoming result at write time
  always_comb begin
    wr_entry        = '0;
    wr_entry[7:0]   = in_data;
    wr_entry[8]     = (in_data == 8'h00);
    wr_entry[9]     = in_data[7];
    wr_entry[10]    = ^in_data;
  end

  // Next-state for the pointers, occupancy and the sticky overrun flag
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q | (in_valid & full);
    // DEPTH is a power of two, so the pointers wrap naturally at AW bits
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state: reset discards every stored entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Entry storage is not reset; contents are only observable while counted
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // Head entry is presented without waiting for out_ready
  always_comb begin
    head_entry = mem_q[rd_ptr_q];
    out_data   = head_entry[7:0];
    out_zero   = head_entry[8];
    out_neg    = head_entry[9];
    out_parity = head_entry[10];
    count      = count_q;
    overrun    = overrun_q;
  end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Scoreboard bench for alu_result_buffer.
// The driver queues expected results when they are issued.
// A negedge monitor checks status and the head entry, and retires each popped entry.
module tb_alu_result_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic          out_zero;
  logic          out_neg;
  logic          out_parity;
  logic [CW-1:0] count;
  logic          overrun;

  alu_result_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .out_parity(out_parity),
    .count     (count),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: an ordered list of accepted results plus the sticky overrun flag
  logic [7:0] sb[$];
  int         cur_count = 0;   // occupancy the DUT should show this cycle
  logic       cur_ovr   = 1'b0;
  logic       mdl_ovr   = 1'b0;
  logic       mon_en    = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // One cycle of stimulus; the acceptance decision uses the model occupancy
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    cur_count = sb.size();
    cur_ovr   = mdl_ovr;
    if (v && cur_count != DEPTH) sb.push_back(d);
    if (v && cur_count == DEPTH) mdl_ovr = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  int'(in_ready),  1);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_count"},     int'(count),     0);
    check({tag, "_overrun"},   int'(overrun),   0);
  endtask

  // Monitor: status every cycle, head entry whenever the model says one exists
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      logic [7:0] e;
      check("in_ready",  int'(in_ready),  int'(cur_count != DEPTH));
      check("out_valid", int'(out_valid), int'(cur_count != 0));
      check("count",     int'(count),     cur_count);
      check("overrun",   int'(overrun),   int'(cur_ovr));
      if (cur_count != 0) begin
        e = sb[0];
        check("out_data",   int'(out_data),   int'(e));
        check("out_zero",   int'(out_zero),   int'(e == 8'd0));
        check("out_neg",    int'(out_neg),    int'($signed(e) < 0));
        check("out_parity", int'(out_parity), $countones(e) % 2);
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    #2;
    check_reset_outputs("por");
    #10;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Single push with the consumer stalled
    step(1'b1, 8'h5A, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);

    // Flag coverage, then pop all four in order
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h80, 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    step(1'b1, 8'h07, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);

    // Fill, overrun attempt, drain
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'h05, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);

    // Preload two, then sustained push+pop across the pointer wrap
    step(1'b1, 8'h10, 1'b0);
    step(1'b1, 8'h11, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h20 + i), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);

    // Full with simultaneous pop: push refused, then accepted next cycle
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    step(1'b1, 8'hAA, 1'b1);
    step(1'b1, 8'hBB, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // Mid-operation reset with three entries held and overrun set
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    @(posedge clk);
    #2;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check_reset_outputs("mid");
    sb.delete();
    cur_count = 0;
    cur_ovr   = 1'b0;
    mdl_ovr   = 1'b0;
    #1;
    rst_n = 1'b1;
    step(1'b1, 8'hC3, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic v;
      logic r;
      v = ($urandom_range(0, 3) != 0);
      r = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(v, 8'($urandom), r);
    end

    // Drain and confirm the model agrees that nothing is left
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    @(posedge clk);
    check("final_drain_empty", sb.size(), 0);
    check("final_out_valid", int'(out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
